// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_pkg
//  Description : Shared types and defaults for the parametrised serial
//                pattern detector (seq_detect_param / seq_hist_cmp).
//                - state_t      : detector FSM state encoding (2-bit)
//                - PKG_DEF_*    : pattern / length / overlap loaded at reset
//                - clamp_len()  : limits a requested length to the maximum
//  Revision    : 1.0  initial release
// ============================================================================
package seq_detect_pkg;

  typedef enum logic [1:0] {
    ST_HUNT     = 2'd0,
    ST_HIT      = 2'd1,
    ST_DISABLED = 2'd2
  } state_t;

  localparam int                   PKG_PAT_W   = 8;
  localparam logic [PKG_PAT_W-1:0] PKG_DEF_PAT = 8'b0000_1010;
  localparam int                   PKG_DEF_LEN = 4;
  localparam bit                   PKG_DEF_OVL = 1'b1;

  // Lengths beyond the physical history width are treated as the maximum.
  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_hist_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : seq_hist_cmp
//  Description : Serial history shift register, fill counter and masked
//                pattern comparator. Reports whether the bit accepted this
//                cycle completes an occurrence of the pattern.
//  Ports       :
//    clk, reset      clock / synchronous active-high reset
//    i_clear         drop all history (configuration reload)
//    i_accept        i_din is taken into the history this cycle
//    i_din           serial data bit
//    i_pat, i_len    active pattern and its length (1..PAT_W)
//    i_ovl           1 = overlapping matches allowed
//    o_match_next    accepted bit completes a match (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module seq_hist_cmp #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic             i_din,
  input  logic [PAT_W-1:0] i_pat,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_ovl,
  output logic             o_match_next
);

  localparam logic [LEN_W-1:0] c_FILL_MAX = LEN_W'(PAT_W);

  // Only PAT_W-1 bits are kept: the oldest bit would be shifted out before
  // it could ever take part in a comparison, so the post-shift history
  // is rebuilt from these plus the incoming bit.
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;

  logic [PAT_W-1:0] w_hist_next;
  logic [LEN_W-1:0] w_fill_inc;
  logic [PAT_W-1:0] w_mask;
  logic             w_match;

  assign w_hist_next = {r_hist, i_din};
  assign w_fill_inc  = (r_fill == c_FILL_MAX) ? r_fill : r_fill + 1'b1;

  // Only the low i_len bits of history/pattern take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(i_len));
    end
  end

  assign w_match = i_accept && (i_len != '0) && (w_fill_inc >= i_len) &&
                   (((w_hist_next ^ i_pat) & w_mask) == '0);

  assign o_match_next = w_match;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_accept) begin
      r_hist <= w_hist_next[PAT_W-2:0];
      // Non-overlap mode: a match consumes its bits, so the next match
      // must be built entirely from fresh input.
      r_fill <= (w_match && !i_ovl) ? '0 : w_fill_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Parametrised Moore serial-pattern detector with a runtime
//                programmable pattern (1..PAT_W bits), overlap/non-overlap
//                mode, input qualifier and saturating match counter.
//  Ports       :
//    clk, reset      clock / synchronous active-high reset
//    i_din           serial data bit
//    i_din_valid     i_din is sampled only when high
//    i_cfg_load      capture i_cfg_pat / i_cfg_len / i_cfg_ovl this cycle
//    i_cfg_pat       pattern, bit [len-1] first-received, bit [0] last
//    i_cfg_len       pattern length (clamped to PAT_W, 0 disables)
//    i_cfg_ovl       1 = overlapping matches allowed
//    o_y             one-cycle match flag per occurrence (Moore)
//    o_match_cnt     saturating match count since reset / cfg load
//    o_active        detector enabled
//  Revision    : 1.0  initial release
// ============================================================================
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = PKG_PAT_W,
  parameter int               LEN_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(PKG_DEF_PAT),
  parameter int               DEF_LEN = PKG_DEF_LEN,
  parameter bit               DEF_OVL = PKG_DEF_OVL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_din,
  input  logic             i_din_valid,
  input  logic             i_cfg_load,
  input  logic [PAT_W-1:0] i_cfg_pat,
  input  logic [LEN_W-1:0] i_cfg_len,
  input  logic             i_cfg_ovl,
  output logic             o_y,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_active
);

  localparam logic [LEN_W-1:0] c_LEN_MAX   = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] c_RST_LEN   = LEN_W'(clamp_len(DEF_LEN, PAT_W));
  localparam state_t           c_RST_STATE = (c_RST_LEN == '0) ? ST_DISABLED : ST_HUNT;

  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic             r_ovl;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  state_t           w_state_next;

  logic [LEN_W-1:0] w_cfg_len;
  logic             w_accept;
  logic             w_match;

  assign w_cfg_len = (i_cfg_len > c_LEN_MAX) ? c_LEN_MAX : i_cfg_len;

  // A configuration load wins over data in the same cycle; that bit is lost.
  assign w_accept  = i_din_valid && !i_cfg_load && (r_state != ST_DISABLED);

  seq_hist_cmp #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_hist_cmp (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (i_cfg_load),
    .i_accept     (w_accept),
    .i_din        (i_din),
    .i_pat        (r_pat),
    .i_len        (r_len),
    .i_ovl        (r_ovl),
    .o_match_next (w_match)
  );

  // Configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat <= DEF_PAT;
      r_len <= c_RST_LEN;
      r_ovl <= DEF_OVL;
    end else if (i_cfg_load) begin
      r_pat <= i_cfg_pat;
      r_len <= w_cfg_len;
      r_ovl <= i_cfg_ovl;
    end
  end

  // Saturating match counter
  always_ff @(posedge clk) begin
    if (reset || i_cfg_load) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_RST_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state. w_match is only ever true for an accepted bit, so an
  // idle cycle (i_din_valid low) falls back from HIT to HUNT.
  always_comb begin
    w_state_next = r_state;
    if (i_cfg_load) begin
      w_state_next = (w_cfg_len == '0) ? ST_DISABLED : ST_HUNT;
    end else begin
      case (r_state)
        ST_HUNT:     w_state_next = w_match ? ST_HIT : ST_HUNT;
        ST_HIT:      w_state_next = w_match ? ST_HIT : ST_HUNT;
        ST_DISABLED: w_state_next = ST_DISABLED;
        default:     w_state_next = ST_HUNT;
      endcase
    end
  end

  assign o_y         = (r_state == ST_HIT);
  assign o_active    = (r_state != ST_DISABLED);
  assign o_match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_param
//  Description : Self-checking bench for seq_detect_param. Two instances
//                share the same stimulus: the default build (CNT_W=8) and a
//                narrow-counter build (CNT_W=2). A queue-based reference
//                model predicts y / match_cnt / active every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_din;
  logic       i_din_valid;
  logic       i_cfg_load;
  logic [7:0] i_cfg_pat;
  logic [3:0] i_cfg_len;
  logic       i_cfg_ovl;

  logic       o_y,  o_active;
  logic [7:0] o_match_cnt;
  logic       o_y2, o_active2;
  logic [1:0] o_match_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_param u_dut (
    .clk         (clk),
    .reset       (reset),
    .i_din       (i_din),
    .i_din_valid (i_din_valid),
    .i_cfg_load  (i_cfg_load),
    .i_cfg_pat   (i_cfg_pat),
    .i_cfg_len   (i_cfg_len),
    .i_cfg_ovl   (i_cfg_ovl),
    .o_y         (o_y),
    .o_match_cnt (o_match_cnt),
    .o_active    (o_active)
  );

  seq_detect_param #(.CNT_W(2)) u_dut_c2 (
    .clk         (clk),
    .reset       (reset),
    .i_din       (i_din),
    .i_din_valid (i_din_valid),
    .i_cfg_load  (i_cfg_load),
    .i_cfg_pat   (i_cfg_pat),
    .i_cfg_len   (i_cfg_len),
    .i_cfg_ovl   (i_cfg_ovl),
    .o_y         (o_y2),
    .o_match_cnt (o_match_cnt2),
    .o_active    (o_active2)
  );

  // ---------------- reference model ----------------
  // Bits accepted since the last clear, oldest first; a match is simply
  // "the last len received bits spell the pattern, first-received = MSB".
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_y;
  bit         m_active;
  int         m_cnt;
  bit         m_hit;
  bit         chk_en = 1'b0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pat = 8'b0000_1010; m_len = 4; m_ovl = 1'b1;
      mq.delete(); m_cnt = 0; m_y = 1'b0; m_active = 1'b1;
    end else if (i_cfg_load) begin
      m_pat = i_cfg_pat;
      m_len = (int'(i_cfg_len) > 8) ? 8 : int'(i_cfg_len);
      m_ovl = i_cfg_ovl;
      mq.delete(); m_cnt = 0; m_y = 1'b0; m_active = (m_len != 0);
    end else if (m_active && i_din_valid) begin
      mq.push_back(i_din);
      if (mq.size() > 16) void'(mq.pop_front());
      m_hit = (mq.size() >= m_len);
      for (int k = 0; k < m_len; k++)
        if (m_hit && (mq[mq.size()-1-k] != m_pat[k])) m_hit = 1'b0;
      m_y = m_hit;
      if (m_hit) begin
        m_cnt++;
        if (!m_ovl) mq.delete();
      end
    end else begin
      m_y = 1'b0;
    end
    chk_en = 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Single compare process: every output of both instances, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("y",       32'(o_y),          32'(m_y));
      check("active",  32'(o_active),     32'(m_active));
      check("cnt",     32'(o_match_cnt),  sat(m_cnt, 255));
      check("y_c2",    32'(o_y2),         32'(m_y));
      check("act_c2",  32'(o_active2),    32'(m_active));
      check("cnt_c2",  32'(o_match_cnt2), sat(m_cnt, 3));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic d, input logic v);
    reset = 1'b0; i_cfg_load = 1'b0; i_din = d; i_din_valid = v;
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic d, input logic v);
    reset = 1'b0; i_cfg_load = 1'b1; i_cfg_pat = p; i_cfg_len = l; i_cfg_ovl = o;
    i_din = d; i_din_valid = v;
    @(negedge clk);
    i_cfg_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_cfg_load = 1'b0; i_din_valid = 1'b0; i_din = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic alt(input int n);  // 1,0,1,0,... n bits
    for (int i = 0; i < n; i++) cyc(1'((i + 1) % 2), 1'b1);
  endtask

  initial begin
    reset = 1'b1; i_din = 1'b0; i_din_valid = 1'b0; i_cfg_load = 1'b0;
    i_cfg_pat = 8'h00; i_cfg_len = 4'd0; i_cfg_ovl = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_y",      32'(o_y),         32'd0);
    check("rst_active", 32'(o_active),    32'd1);
    check("rst_cnt",    32'(o_match_cnt), 32'd0);

    // Default 1010 overlapping: hits after bits 4 and 6
    alt(4);  check("t1_y_b4", 32'(o_y), 32'd1);
    alt(1);  check("t1_y_b5", 32'(o_y), 32'd0);
    cyc(1'b0, 1'b1);
    check("t1_y_b6", 32'(o_y), 32'd1);
    check("t1_cnt",  32'(o_match_cnt), 32'd2);

    // Non-overlap: hits after bits 4 and 8 only
    load(8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b0);
    alt(4);  check("t2_y_b4", 32'(o_y), 32'd1);
    alt(2);  check("t2_y_b6", 32'(o_y), 32'd0);
    alt(2);  check("t2_y_b8", 32'(o_y), 32'd1);
    check("t2_cnt", 32'(o_match_cnt), 32'd2);

    // Qualifier gaps do not break a match
    load(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0);
    alt(2);
    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1); check("t3_y_b3", 32'(o_y), 32'd0);
    cyc(1'b0, 1'b1); check("t3_y_b4", 32'(o_y), 32'd1);
    check("t3_cnt", 32'(o_match_cnt), 32'd1);

    // 111 overlapping on six 1s: back-to-back y
    load(8'b0000_0111, 4'd3, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b1);
    check("t4_y_b2", 32'(o_y), 32'd0);
    cyc(1'b1, 1'b1); check("t4_y_b3", 32'(o_y), 32'd1);
    repeat (3) cyc(1'b1, 1'b1);
    check("t4_y_b6", 32'(o_y), 32'd1);
    check("t4_cnt",  32'(o_match_cnt), 32'd4);

    // Counter saturation on the 2-bit instance, then disable with len=0
    load(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0);
    alt(12);
    check("t5_cnt_c2", 32'(o_match_cnt2), 32'd3);
    check("t5_cnt",    32'(o_match_cnt),  32'd5);
    load(8'b0000_1010, 4'd0, 1'b1, 1'b1, 1'b1);
    check("t5_active", 32'(o_active), 32'd0);
    check("t5_cnt0",   32'(o_match_cnt), 32'd0);
    alt(4);
    check("t5_dis_y",   32'(o_y), 32'd0);
    check("t5_dis_cnt", 32'(o_match_cnt2), 32'd0);

    // Reset and cfg_load mid-pattern discard partial history
    load(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0);
    alt(3);
    do_reset();
    cyc(1'b0, 1'b1); check("t6_rst_y", 32'(o_y), 32'd0);
    alt(3);
    load(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b1);   // coincident bit dropped
    cyc(1'b0, 1'b1); check("t6_ld_y", 32'(o_y), 32'd0);
    alt(3);          check("t6_y_b3", 32'(o_y), 32'd0);
    cyc(1'b0, 1'b1); check("t6_y_b4", 32'(o_y), 32'd1);

    // Length clamp: len=15 behaves as len=8
    load(8'b1111_1111, 4'd15, 1'b1, 1'b0, 1'b0);
    repeat (7) cyc(1'b1, 1'b1);
    check("t7_y_b7", 32'(o_y), 32'd0);
    cyc(1'b1, 1'b1); check("t7_y_b8", 32'(o_y), 32'd1);

    // Randomised traffic, model-checked every cycle
    for (int it = 0; it < 4000; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        do_reset();
      end else if (r < 4) begin
        logic [3:0] l;
        if ($urandom_range(0, 3) == 0) l = 4'($urandom_range(0, 15));
        else                           l = 4'($urandom_range(1, 3));
        load(8'($urandom), l, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
